multicycle_ctrl: RTL

Multi-cycle control unit that sequences the single-datapath RISC core one instruction at a time. It gates PC advance and instruction-register load, and decodes op/fn into the datapath control bus (alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch_instr). It waits on a data-memory ready handshake, counts retired instructions, and halts on request, illegal opcode or memory timeout.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/op_class_decode.sv | 40 ++++
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle control unit.
// Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  typedef enum logic [2:0] {
    CLS_RTYPE  = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_SHIFT  = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_NONE   = 3'd6
  } op_class_e;

  localparam logic [5:0] OP_RTYPE      = 6'b000000;
  localparam logic [5:0] OP_IMM        = 6'b000001;
  localparam logic [5:0] OP_SHIFT      = 6'b000010;
  localparam logic [5:0] OP_LOAD       = 6'b000011;
  localparam logic [5:0] OP_STORE      = 6'b000100;
  localparam logic [2:0] OP_BRANCH_GRP = 3'b001;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FN_R  = 2'b10;
  localparam logic [1:0] ALU_FN_I  = 2'b11;

  localparam logic [1:0] SRC_REG    = 2'b00;
  localparam logic [1:0] SRC_IMM    = 2'b01;
  localparam logic [1:0] SRC_OFFSET = 2'b10;
  localparam logic [1:0] SRC_SHAMT  = 2'b11;

  function automatic logic is_mem_class(input op_class_e cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/op_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : op_class_decode
// Purpose  : Combinational opcode/function classifier with illegal/NOP flags.
// Revision : 1.0  initial release
// ============================================================================
module op_class_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [10:0] fn,
  output op_class_e   op_class,
  output logic        illegal,
  output logic        nop
);

  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    nop      = 1'b0;
    if (op[5:3] == OP_BRANCH_GRP) begin
      op_class = CLS_BRANCH;
    end else begin
      case (op)
        OP_RTYPE: begin
          op_class = CLS_RTYPE;
          // R-type with an all-zero function field retires without writeback
          nop      = (fn == 11'd0);
        end
        OP_IMM:   op_class = CLS_IMM;
        OP_SHIFT: op_class = CLS_SHIFT;
        OP_LOAD:  op_class = CLS_LOAD;
        OP_STORE: op_class = CLS_STORE;
        default:  illegal  = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Sequences one instruction at a time through FETCH..WB and drives
//            the datapath control bus, with halt, illegal-op and mem timeout.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic [5:0]       op,
  input  logic [10:0]      fn,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             branch_instr,
  output logic             busy,
  output logic             halted,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [2:0]       w_after_retire;
  op_class_e        r_class;
  op_class_e        w_dec_class;
  logic             r_nop;
  logic             w_dec_nop;
  logic             w_dec_illegal;
  logic [7:0]       r_wait;
  logic             w_wait_expired;
  logic             w_timeout;
  logic             r_err_illegal;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_retired;

  op_class_decode u_op_class_decode (
    .op       (op),
    .fn       (fn),
    .op_class (w_dec_class),
    .illegal  (w_dec_illegal),
    .nop      (w_dec_nop)
  );

  assign w_wait_expired = (r_wait == WAIT_LAST);
  assign w_timeout      = (r_state == ST_MEM) && !mem_ready && w_wait_expired;
  assign w_after_retire = halt_req ? ST_HALT : ST_FETCH;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (halt_req)   w_next_state = ST_HALT;
        else if (start) w_next_state = ST_FETCH;
      end
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = w_dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (r_class == CLS_BRANCH)      w_next_state = w_after_retire;
        else if (is_mem_class(r_class)) w_next_state = ST_MEM;
        else                            w_next_state = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)
          w_next_state = (r_class == CLS_LOAD) ? ST_WB : w_after_retire;
        else if (w_wait_expired)
          w_next_state = ST_HALT;
      end
      ST_WB:   w_next_state = w_after_retire;
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    alu_op       = ALU_ADD;
    alu_src      = SRC_REG;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    branch_instr = 1'b0;
    case (r_state)
      ST_FETCH: ir_load = 1'b1;
      ST_EXEC: begin
        case (r_class)
          CLS_RTYPE: alu_op = ALU_FN_R;
          CLS_IMM: begin
            alu_op  = ALU_FN_I;
            alu_src = SRC_IMM;
          end
          CLS_SHIFT: begin
            alu_op  = ALU_FN_R;
            alu_src = SRC_SHAMT;
          end
          CLS_LOAD, CLS_STORE: alu_src = SRC_OFFSET;
          CLS_BRANCH: begin
            alu_op       = ALU_SUB;
            branch_instr = 1'b1;
            pc_write     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // address computation stays on the bus for the whole access
        alu_src   = SRC_OFFSET;
        mem_read  = (r_class == CLS_LOAD);
        mem_write = (r_class == CLS_STORE);
        pc_write  = (r_class == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_write  = !r_nop;
        mem_to_reg = (r_class == CLS_LOAD);
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_class       <= CLS_NONE;
      r_nop         <= 1'b0;
      r_wait        <= 8'd0;
      r_err_illegal <= 1'b0;
      r_err_timeout <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec_class;
        r_nop   <= w_dec_nop;
      end
      if ((r_state == ST_MEM) && !mem_ready) r_wait <= r_wait + 8'd1;
      else                                   r_wait <= 8'd0;
      if ((r_state == ST_DECODE) && w_dec_illegal) r_err_illegal <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;
      if (pc_write)  r_retired     <= r_retired + 1'b1;
    end
  end

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted      = (r_state == ST_HALT);
  assign err_illegal = r_err_illegal;
  assign err_timeout = r_err_timeout;
  assign retired     = r_retired;

endmodule
`default_nettype wire
